// File: rtl/oduzimanje_serijsko.sv
// Bit-serial 7-bit subtractor (z = a - b), LSB first, one full-subtractor cell plus borrow flop.
// Define ODUZ_FLAGS_EN to build the zero/negative/overflow status flags; otherwise they read 0.
module oduzimanje_serijsko (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic       busy,
  output logic       done,
  output logic [6:0] z,
  output logic       borrow,
  output logic       zero,
  output logic       negative,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic [6:0]  a_sr_reg, b_sr_reg, res_sr_reg;
  logic        br_reg;
  logic [6:0]  z_reg;
  logic        borrow_reg;

  logic        d_next, br_next;
  logic [6:0]  res_next;
  logic        last_bit;

  // Full-subtractor cell on the current LSBs
  assign d_next   = a_sr_reg[0] ^ b_sr_reg[0] ^ br_reg;
  assign br_next  = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & br_reg);
  assign res_next = {d_next, res_sr_reg[6:1]};
  assign last_bit = (state_reg == SHIFT) && (cnt_reg == 3'd6);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == 3'd6) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= 3'd0;
      a_sr_reg   <= 7'd0;
      b_sr_reg   <= 7'd0;
      res_sr_reg <= 7'd0;
      br_reg     <= 1'b0;
      z_reg      <= 7'd0;
      borrow_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_sr_reg <= a;
        b_sr_reg <= b;
        br_reg   <= 1'b0;
        cnt_reg  <= 3'd0;
      end else if (state_reg == SHIFT) begin
        a_sr_reg   <= {1'b0, a_sr_reg[6:1]};
        b_sr_reg   <= {1'b0, b_sr_reg[6:1]};
        res_sr_reg <= res_next;
        br_reg     <= br_next;
        cnt_reg    <= cnt_reg + 3'd1;
      end
      // Visible results only move when the final bit lands
      if (last_bit) begin
        z_reg      <= res_next;
        borrow_reg <= br_next;
      end
    end
  end

`ifdef ODUZ_FLAGS_EN
  logic a_msb_reg, b_msb_reg;
  logic zero_reg, negative_reg, overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      // Signs are captured up front because the operand shifters discard them
      if (state_reg == IDLE && start) begin
        a_msb_reg <= a[6];
        b_msb_reg <= b[6];
      end
      if (last_bit) begin
        zero_reg     <= ~|res_next;
        negative_reg <= res_next[6];
        overflow_reg <= (a_msb_reg != b_msb_reg) && (res_next[6] != a_msb_reg);
      end
    end
  end

  assign zero     = zero_reg;
  assign negative = negative_reg;
  assign overflow = overflow_reg;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign overflow = 1'b0;
`endif

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign z      = z_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_oduzimanje_serijsko.sv
// Directed bench for the bit-serial subtractor: vector table plus handshake, lockout and reset sequences.
module tb_oduzimanje_serijsko;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] a, b;
  logic       busy, done;
  logic [6:0] z;
  logic       borrow, zero, negative, overflow;

  int checks = 0;
  int errors = 0;

  oduzimanje_serijsko dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .z(z), .borrow(borrow),
    .zero(zero), .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] va, vb, ez;
    logic       ebr, ezr, eng, eov;
  } vec_t;

  vec_t vecs [8];

  // Results captured by run_op
  int         got_lat;
  logic [6:0] got_z;
  logic       got_br, got_zr, got_ng, got_ov;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic flag_exp(input logic f);
`ifdef ODUZ_FLAGS_EN
    return f;
`else
    return 1'b0;
`endif
  endfunction

  // Called #1 after a rising edge with the DUT idle; start is accepted on the next edge.
  task automatic run_op(input logic [6:0] ta, input logic [6:0] tb_v);
    int         busy_low;
    int         unstable;
    logic [6:0] prev_z;
    prev_z   = z;
    busy_low = 0;
    unstable = 0;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 7'($urandom); b = 7'($urandom);
    got_lat = 0;
    while (got_lat < 20) begin
      if (!busy) busy_low++;
      if (!done && z != prev_z) unstable++;
      @(posedge clk); #1;
      got_lat++;
      if (done) break;
    end
    if (!busy) busy_low++;
    got_z = z; got_br = borrow; got_zr = zero; got_ng = negative; got_ov = overflow;
    check("latency", got_lat, 7);
    check("busy_during_op", busy_low, 0);
    check("z_stable_during_op", unstable, 0);
    @(posedge clk); #1;
    check("done_single_pulse", done, 0);
    check("busy_fall", busy, 0);
  endtask

  initial begin
    vecs[0] = '{7'd5,    7'd3,    7'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{7'd3,    7'd5,    7'h7E, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{7'h40,   7'h01,   7'h3F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{7'h55,   7'h55,   7'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7'h00,   7'h7F,   7'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7'h3F,   7'h7F,   7'h40, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{7'h7F,   7'h00,   7'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{7'h00,   7'h00,   7'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = 7'd0; b = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_borrow", borrow, 0);
    check("rst_zero", zero, 0);
    check("rst_negative", negative, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: each run_op starts one cycle after the previous done, i.e. back-to-back
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb);
      $display("op %0d: a=0x%0h b=0x%0h -> z=0x%0h borrow=%0d zero=%0d neg=%0d ovf=%0d lat=%0d",
               i, vecs[i].va, vecs[i].vb, got_z, got_br, got_zr, got_ng, got_ov, got_lat);
      check("z", got_z, vecs[i].ez);
      check("borrow", got_br, vecs[i].ebr);
      check("zero", got_zr, flag_exp(vecs[i].ezr));
      check("negative", got_ng, flag_exp(vecs[i].eng));
      check("overflow", got_ov, flag_exp(vecs[i].eov));
    end

    // Busy lockout: a second start while busy must be dropped
    begin
      int done_cnt;
      done_cnt = 0;
      a = 7'd10; b = 7'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a = 7'd1; b = 7'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (done) begin
          done_cnt++;
          check("lockout_z", z, 6);
        end
        @(posedge clk); #1;
      end
      $display("lockout: done pulses=%0d z=0x%0h busy=%0d", done_cnt, z, busy);
      check("lockout_done_count", done_cnt, 1);
      check("lockout_idle", busy, 0);
    end

    // Reset in the 4th SHIFT cycle aborts the operation
    begin
      int done_cnt;
      done_cnt = 0;
      a = 7'd20; b = 7'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      $display("abort: busy=%0d done=%0d z=0x%0h borrow=%0d", busy, done, z, borrow);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_z", z, 0);
      check("abort_borrow", borrow, 0);
      for (int c = 0; c < 12; c++) begin
        if (done) done_cnt++;
        @(posedge clk); #1;
      end
      check("abort_no_done", done_cnt, 0);
    end

    // Reset and start together: start discarded
    rst = 1'b1; start = 1'b1; a = 7'd9; b = 7'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    $display("rst+start: busy=%0d", busy);
    check("rst_start_busy", busy, 0);

    run_op(7'd20, 7'd7);
    $display("after abort: a=20 b=7 -> z=0x%0h borrow=%0d", got_z, got_br);
    check("post_abort_z", got_z, 13);
    check("post_abort_borrow", got_br, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
